nios_qsys_cpu_0_ocimem_arbiter: RTL and testbench
=================================================

Name: nios_qsys_cpu_0_ocimem_arbiter

Overview:
- Arbitrates a single-port on-chip debug RAM (OCI memory) between two requesters.
- Requester 1 is the JTAG debug path. It delivers single-cycle take_action strobes in the sysclk domain and cannot be stalled.
- Requester 2 is the CPU debug-mode Avalon slave port, which can be stalled with waitrequest.
- The block holds the auto-incrementing JTAG address, sequences read/write cycles and returns JTAG read data on MonDReg with monitor_ready.

Parameters:
- ADDR_W, 8, OCI RAM word-address width; RAM depth is 2^ADDR_W 32-bit words.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- jdo  in  38  JTAG shift data, sampled on strobes
- take_action_ocimem_a  in  1  strobe: load JTAG address from jdo[ADDR_W+16:17]
- take_action_ocimem_b  in  1  strobe: write jdo[34:3] at JTAG address, then increment address
- take_no_action_ocimem_a  in  1  strobe: read at JTAG address, then increment address
- MonDReg  out  32  last JTAG read data
- monitor_ready  out  1  last JTAG operation complete
- jtag_busy  out  1  JTAG operation pending or in flight
- jtag_overrun  out  1  sticky flag: a JTAG strobe was dropped
- cpu_address  in  ADDR_W  CPU word address
- cpu_read  in  1  CPU read request
- cpu_write  in  1  CPU write request
- cpu_writedata  in  32  CPU write data
- cpu_byteenable  in  4  CPU byte enables
- cpu_readdata  out  32  CPU read data
- cpu_waitrequest  out  1  stall CPU
- ram_addr  out  ADDR_W  RAM address
- ram_wren  out  1  RAM write enable
- ram_byteenable  out  4  RAM byte enables
- ram_wrdata  out  32  RAM write data
- ram_rddata  in  32  RAM read data, valid one cycle after address

Behaviour:
- Reset (synchronous, active-high) clears all registers: FSM=IDLE, pending=0, jaddr=0, MonDReg=0, monitor_ready=0, jtag_overrun=0.
- While reset is asserted: cpu_waitrequest=1, ram_wren=0. A reset during any operation aborts it; no RAM write is issued in the reset cycle.
- JTAG capture, in the strobe cycle:
  - If not busy, take_action_ocimem_a loads jaddr, clears monitor_ready and clears jtag_overrun (no RAM access).
  - take_action_ocimem_b or take_no_action_ocimem_a registers a pending op (write flag plus data jdo[34:3]).
- Strobe conflicts:
  - Any strobe while jtag_busy=1 is dropped and sets jtag_overrun.
  - Multiple strobes in one cycle: the address load wins, the other strobes are dropped and jtag_overrun is set.
- jtag_busy = pending OR state==J_RD.
- FSM states: IDLE, J_RD, C_RD.
- IDLE with pending:
  - JTAG has fixed priority; issue ram_addr=jaddr, ram_byteenable=4'hF.
  - Write: ram_wren=1, jaddr++, pending cleared, monitor_ready<=1, stay in IDLE.
  - Read: jaddr++, pending cleared, go to J_RD.
  - cpu_waitrequest=1 in this cycle.
- IDLE with no pending, cpu_write:
  - ram_addr=cpu_address, ram_wren=1, byteenable/data passed through.
  - cpu_waitrequest=0, so the write completes in one cycle.
- IDLE with no pending, cpu_read: drive ram_addr=cpu_address, cpu_waitrequest=1, go to C_RD.
- J_RD: MonDReg<=ram_rddata, monitor_ready<=1, go to IDLE; cpu_waitrequest=1.
- C_RD: cpu_readdata=ram_rddata, cpu_waitrequest=0, go to IDLE. The CPU holds cpu_read per Avalon rules.
- cpu_read and cpu_write asserted together: undefined input; treat as a read.
- Latency:
  - JTAG read strobe in cycle N: RAM access in N+1, MonDReg/monitor_ready valid from N+3.
  - JTAG write strobe in cycle N: written in N+1.
  - CPU read: 2 cycles minimum. CPU write: 1 cycle minimum.
  - A CPU request arriving while JTAG is busy stalls at most 2 cycles per JTAG op.
- jaddr increments wrap modulo 2^ADDR_W (all-ones -> 0).
- ram_wren=0 in all states and cases not listed above.
- cpu_readdata outside C_RD is don't-care; drive ram_rddata.

Test Plan:
- Reset mid-op: JTAG read strobe, then reset asserted in the J_RD cycle -> MonDReg=0, monitor_ready=0, jtag_busy=0, no ram_wren.
- JTAG sequence: load addr 0x10, write 0xDEADBEEF, write 0x12345678, load 0x10, read, read -> MonDReg=0xDEADBEEF and then 0x12345678, each valid 3 cycles after its strobe; jaddr ends at 0x12.
- Wrap-around: load 0xFF, write 0xA5A5A5A5, then read -> the read returns RAM[0x00], not RAM[0xFF]; the write landed at 0xFF.
- Contention: CPU read of 0x20 held while a JTAG write strobe arrives in the same cycle -> JTAG write issues first, CPU waitrequest low 2 cycles later with correct data.
- Overrun: JTAG read strobe followed by a second strobe 1 cycle later -> second strobe dropped, jtag_overrun=1 until the next take_action_ocimem_a.
- CPU byteenable: write 0xFFFFFFFF, then write 0x00000000 with byteenable 4'b0101 -> read returns 0xFF00FF00.

Source files
------------

// File: rtl/nios_qsys_cpu_0_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between the JTAG debug path (cannot stall)
// and the CPU debug-mode Avalon slave (stalled through waitrequest).
module nios_qsys_cpu_0_ocimem_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              jtag_busy,
    output logic              jtag_overrun,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    input  logic [3:0]        cpu_byteenable,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [3:0]        ram_byteenable,
    output logic [31:0]       ram_wrdata,
    input  logic [31:0]       ram_rddata
);

    typedef enum logic [1:0] {IDLE, J_RD, C_RD} state_t;

    state_t            state_q, state_d;
    logic              pend_q, pend_d;
    logic              pwr_q, pwr_d;
    logic [31:0]       pdata_q, pdata_d;
    logic [ADDR_W-1:0] jaddr_q, jaddr_d;
    logic [31:0]       mon_q, mon_d;
    logic              mrdy_q, mrdy_d;
    logic              ovr_q, ovr_d;

    logic busy, stb_any, stb_multi, op_acc;
    logic unused_jdo;

    assign unused_jdo = &{1'b0, jdo[37:35], jdo[2:0]};

    assign busy      = pend_q | (state_q == J_RD);
    assign stb_any   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign stb_multi = (take_action_ocimem_a & take_action_ocimem_b) |
                       (take_action_ocimem_a & take_no_action_ocimem_a) |
                       (take_action_ocimem_b & take_no_action_ocimem_a);
    // A JTAG op accepted this cycle must issue next cycle, so it holds off a CPU read start.
    assign op_acc    = ~busy & ~take_action_ocimem_a &
                       (take_action_ocimem_b | take_no_action_ocimem_a);

    assign MonDReg       = mon_q;
    assign monitor_ready = mrdy_q;
    assign jtag_busy     = busy;
    assign jtag_overrun  = ovr_q;
    assign cpu_readdata  = ram_rddata;

    always_comb begin
        state_d         = state_q;
        pend_d          = pend_q;
        pwr_d           = pwr_q;
        pdata_d         = pdata_q;
        jaddr_d         = jaddr_q;
        mon_d           = mon_q;
        mrdy_d          = mrdy_q;
        ovr_d           = ovr_q;
        ram_addr        = cpu_address;
        ram_wren        = 1'b0;
        ram_byteenable  = cpu_byteenable;
        ram_wrdata      = cpu_writedata;
        cpu_waitrequest = 1'b1;

        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    ram_addr       = jaddr_q;
                    ram_byteenable = 4'hF;
                    ram_wrdata     = pdata_q;
                    jaddr_d        = jaddr_q + ADDR_W'(1);
                    pend_d         = 1'b0;
                    if (pwr_q) begin
                        ram_wren = 1'b1;
                        mrdy_d   = 1'b1;
                    end else begin
                        state_d = J_RD;
                    end
                end else if (cpu_read) begin
                    if (!op_acc) state_d = C_RD;
                end else if (cpu_write) begin
                    ram_wren        = 1'b1;
                    cpu_waitrequest = 1'b0;
                end
            end
            J_RD: begin
                mon_d   = ram_rddata;
                mrdy_d  = 1'b1;
                state_d = IDLE;
            end
            C_RD: begin
                cpu_waitrequest = 1'b0;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (stb_any) begin
            if (busy) begin
                ovr_d = 1'b1;
            end else if (take_action_ocimem_a) begin
                jaddr_d = jdo[ADDR_W+16:17];
                mrdy_d  = 1'b0;
                ovr_d   = stb_multi;
            end else begin
                pend_d  = 1'b1;
                pwr_d   = take_action_ocimem_b;
                pdata_d = jdo[34:3];
                ovr_d   = ovr_q | stb_multi;
            end
        end

        if (reset) begin
            ram_wren        = 1'b0;
            cpu_waitrequest = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            pwr_q   <= 1'b0;
            pdata_q <= '0;
            jaddr_q <= '0;
            mon_q   <= '0;
            mrdy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            pwr_q   <= pwr_d;
            pdata_q <= pdata_d;
            jaddr_q <= jaddr_d;
            mon_q   <= mon_d;
            mrdy_q  <= mrdy_d;
            ovr_q   <= ovr_d;
        end
    end

endmodule

// File: tb/tb_nios_qsys_cpu_0_ocimem_arbiter.sv
// Bench for the OCI memory arbiter: directed scenarios plus random traffic, all
// checked against a timestamp-based behavioural model and a bench-owned RAM.
module tb_nios_qsys_cpu_0_ocimem_arbiter;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [37:0]   jdo;
    logic          ta_a, ta_b, tna_a;
    logic [31:0]   MonDReg;
    logic          monitor_ready, jtag_busy, jtag_overrun;
    logic [AW-1:0] cpu_address;
    logic          cpu_read, cpu_write;
    logic [31:0]   cpu_writedata;
    logic [3:0]    cpu_byteenable;
    logic [31:0]   cpu_readdata;
    logic          cpu_waitrequest;
    logic [AW-1:0] ram_addr;
    logic          ram_wren;
    logic [3:0]    ram_byteenable;
    logic [31:0]   ram_wrdata;
    logic [31:0]   ram_rddata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nios_qsys_cpu_0_ocimem_arbiter #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .jdo(jdo),
        .take_action_ocimem_a(ta_a), .take_action_ocimem_b(ta_b),
        .take_no_action_ocimem_a(tna_a),
        .MonDReg(MonDReg), .monitor_ready(monitor_ready),
        .jtag_busy(jtag_busy), .jtag_overrun(jtag_overrun),
        .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
        .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest),
        .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_byteenable(ram_byteenable),
        .ram_wrdata(ram_wrdata), .ram_rddata(ram_rddata)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Bench RAM: registered read, byte-enabled write; pattern-filled on first reset.
    logic [31:0] ram [0:255];
    logic        ram_clr;
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'hC0DE0000 | 32'(i);
        end else if (ram_wren) begin
            if (ram_byteenable[0]) ram[ram_addr][7:0]   <= ram_wrdata[7:0];
            if (ram_byteenable[1]) ram[ram_addr][15:8]  <= ram_wrdata[15:8];
            if (ram_byteenable[2]) ram[ram_addr][23:16] <= ram_wrdata[23:16];
            if (ram_byteenable[3]) ram[ram_addr][31:24] <= ram_wrdata[31:24];
        end
        ram_rddata <= ram[ram_addr];
    end

    // Behavioural model: JTAG op and CPU read are tracked by the cycle in which
    // their data phase happens, rather than by any state encoding.
    logic [31:0] mem_m [0:255];
    bit          model_on = 0;
    bit          m_pend, m_pwr, m_rdy, m_ovr, m_busy, m_acc, e_wait, e_wren;
    logic [31:0] m_pdata, m_mon, e_data;
    logic [7:0]  m_jaddr, m_jrd_addr, m_crd_addr, e_addr;
    logic [3:0]  e_be;
    int          m_jrd_at, m_crd_at, cyc = 0, nstb;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            chk("rst_wait", 32'(cpu_waitrequest), 32'd1);
            chk("rst_wren", 32'(ram_wren), 32'd0);
            if (!model_on)
                for (int i = 0; i < 256; i++) mem_m[i] = 32'hC0DE0000 | 32'(i);
            model_on = 1;
            m_pend = 0; m_jaddr = 0; m_mon = 0; m_rdy = 0; m_ovr = 0;
            m_jrd_at = -1; m_crd_at = -1;
        end else if (model_on) begin
            m_busy = m_pend || (m_jrd_at == cyc);
            chk("m_busy", 32'(jtag_busy), 32'(m_busy));
            chk("m_mon", MonDReg, m_mon);
            chk("m_rdy", 32'(monitor_ready), 32'(m_rdy));
            chk("m_ovr", 32'(jtag_overrun), 32'(m_ovr));
            nstb  = int'(ta_a) + int'(ta_b) + int'(tna_a);
            m_acc = !m_busy && !ta_a && (ta_b || tna_a);
            e_wait = 1; e_wren = 0; e_addr = 0; e_be = 0; e_data = 0;
            if (m_jrd_at == cyc) begin
                m_mon = mem_m[m_jrd_addr];
                m_rdy = 1;
            end else if (m_crd_at == cyc) begin
                e_wait = 0;
                chk("m_cpu_rdata", cpu_readdata, mem_m[m_crd_addr]);
            end else if (m_pend) begin
                if (m_pwr) begin
                    e_wren = 1; e_addr = m_jaddr; e_be = 4'hF; e_data = m_pdata;
                    mem_m[m_jaddr] = m_pdata;
                    m_rdy = 1;
                end else begin
                    m_jrd_at = cyc + 1; m_jrd_addr = m_jaddr;
                end
                m_jaddr = m_jaddr + 8'd1;
                m_pend = 0;
            end else if (cpu_read) begin
                if (!m_acc) begin m_crd_at = cyc + 1; m_crd_addr = cpu_address; end
            end else if (cpu_write) begin
                e_wait = 0; e_wren = 1; e_addr = cpu_address;
                e_be = cpu_byteenable; e_data = cpu_writedata;
                for (int b = 0; b < 4; b++)
                    if (cpu_byteenable[b]) mem_m[cpu_address][8*b +: 8] = cpu_writedata[8*b +: 8];
            end
            chk("m_wait", 32'(cpu_waitrequest), 32'(e_wait));
            chk("m_wren", 32'(ram_wren), 32'(e_wren));
            if (e_wren) begin
                chk("m_waddr", 32'(ram_addr), 32'(e_addr));
                chk("m_wbe", 32'(ram_byteenable), 32'(e_be));
                chk("m_wdata", ram_wrdata, e_data);
            end
            if (nstb > 0) begin
                if (m_busy) m_ovr = 1;
                else if (ta_a) begin
                    m_jaddr = jdo[24:17]; m_rdy = 0; m_ovr = (nstb > 1);
                end else begin
                    m_pend = 1; m_pwr = ta_b; m_pdata = jdo[34:3];
                    if (nstb > 1) m_ovr = 1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // kind: 0 = address load, 1 = write, 2 = read; one-cycle strobe
    task automatic jstb(input int kind, input logic [31:0] v);
        jdo = '0;
        if (kind == 0) jdo[24:17] = v[7:0];
        if (kind == 1) jdo[34:3] = v;
        ta_a = (kind == 0); ta_b = (kind == 1); tna_a = (kind == 2);
        tick(1);
        ta_a = 0; ta_b = 0; tna_a = 0;
    endtask

    task automatic cpu_xfer(input bit wr, input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] be, output logic [31:0] rd);
        bit done = 0;
        cpu_address = a; cpu_writedata = d; cpu_byteenable = be;
        cpu_write = wr; cpu_read = !wr;
        rd = '0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (!cpu_waitrequest) begin done = 1; rd = cpu_readdata; end
        end
        chk("cpu_xfer_done", 32'(done), 32'd1);
        @(posedge clk); #1;
        cpu_write = 0; cpu_read = 0;
    endtask

    logic [31:0] rdv;
    logic [63:0] rr;
    bit          cdone;
    int          r;

    initial begin
        reset = 1; ram_clr = 1; jdo = '0; ta_a = 0; ta_b = 0; tna_a = 0;
        cpu_read = 0; cpu_write = 1; cpu_address = '0; cpu_writedata = 32'h1;
        cpu_byteenable = 4'hF;
        tick(3);
        reset = 0; ram_clr = 0; cpu_write = 0;
        @(negedge clk);
        chk("rst_mon", MonDReg, 32'h0);
        chk("rst_rdy", 32'(monitor_ready), 32'd0);
        chk("rst_busy", 32'(jtag_busy), 32'd0);
        chk("rst_ovr", 32'(jtag_overrun), 32'd0);
        tick(1);

        // JTAG write/read sequence with auto-increment
        jstb(0, 32'h10); jstb(1, 32'hDEADBEEF); tick(1);
        jstb(1, 32'h12345678); tick(1);
        jstb(0, 32'h10); jstb(2, 0); tick(2);
        @(negedge clk);
        chk("seq_rd0", MonDReg, 32'hDEADBEEF);
        chk("seq_rdy", 32'(monitor_ready), 32'd1);
        tick(1);
        jstb(2, 0); tick(1);
        @(negedge clk); chk("seq_lat", MonDReg, 32'hDEADBEEF);
        tick(1);
        @(negedge clk); chk("seq_rd1", MonDReg, 32'h12345678);
        tick(1);
        jstb(1, 32'h0BADF00D);
        @(negedge clk);
        chk("seq_wren", 32'(ram_wren), 32'd1);
        chk("seq_jaddr", 32'(ram_addr), 32'h12);
        tick(1);

        // Reset landing in the JTAG read data cycle
        jstb(2, 0); tick(1);
        reset = 1;
        @(negedge clk); chk("rmid_wren", 32'(ram_wren), 32'd0);
        tick(1); reset = 0;
        @(negedge clk);
        chk("rmid_mon", MonDReg, 32'h0);
        chk("rmid_rdy", 32'(monitor_ready), 32'd0);
        chk("rmid_busy", 32'(jtag_busy), 32'd0);
        tick(1);

        // Address wrap
        jstb(0, 32'hFF); jstb(1, 32'hA5A5A5A5);
        @(negedge clk);
        chk("wrap_waddr", 32'(ram_addr), 32'hFF);
        chk("wrap_wdata", ram_wrdata, 32'hA5A5A5A5);
        tick(1);
        jstb(2, 0);
        @(negedge clk); chk("wrap_raddr", 32'(ram_addr), 32'h00);
        tick(2);
        @(negedge clk);
        chk("wrap_rd", MonDReg, 32'hC0DE0000);
        chk("wrap_ramff", ram[255], 32'hA5A5A5A5);
        tick(1);

        // CPU read colliding with a JTAG write strobe
        cpu_read = 1; cpu_address = 8'h20;
        jdo = '0; jdo[34:3] = 32'h5555AAAA; ta_b = 1;
        @(negedge clk); chk("cont_w0", 32'(cpu_waitrequest), 32'd1);
        tick(1); ta_b = 0;
        @(negedge clk);
        chk("cont_jwr", 32'(ram_wren), 32'd1);
        chk("cont_jaddr", 32'(ram_addr), 32'h01);
        chk("cont_w1", 32'(cpu_waitrequest), 32'd1);
        tick(1);
        @(negedge clk); chk("cont_w2", 32'(cpu_waitrequest), 32'd1);
        tick(1);
        @(negedge clk);
        chk("cont_w3", 32'(cpu_waitrequest), 32'd0);
        chk("cont_rd", cpu_readdata, 32'hC0DE0020);
        tick(1); cpu_read = 0;

        // Overrun: second strobe while a read is in flight
        jstb(2, 0);
        jdo = '0; jdo[34:3] = 32'h77777777; ta_b = 1;
        tick(1); ta_b = 0;
        @(negedge clk);
        chk("ovr_set", 32'(jtag_overrun), 32'd1);
        chk("ovr_nowr", 32'(ram_wren), 32'd0);
        tick(3);
        @(negedge clk); chk("ovr_sticky", 32'(jtag_overrun), 32'd1);
        tick(1);
        jstb(0, 32'h30);
        @(negedge clk); chk("ovr_clr", 32'(jtag_overrun), 32'd0);
        tick(1);

        // CPU byte enables
        cpu_xfer(1, 8'h40, 32'hFFFFFFFF, 4'hF, rdv);
        cpu_xfer(1, 8'h40, 32'h00000000, 4'b0101, rdv);
        cpu_xfer(0, 8'h40, 32'h0, 4'hF, rdv);
        chk("be_rd", rdv, 32'hFF00FF00);

        // Random traffic; the model process checks every cycle
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            cdone = (cpu_read || cpu_write) && !cpu_waitrequest;
            @(posedge clk); #1;
            reset = ($urandom_range(0, 299) == 0);
            rr = {$urandom(), $urandom()};
            jdo = rr[37:0];
            ta_a = 0; ta_b = 0; tna_a = 0;
            r = int'($urandom_range(0, 99));
            if (r < 8) ta_a = 1;
            else if (r < 20) ta_b = 1;
            else if (r < 32) tna_a = 1;
            else if (r < 34) begin ta_a = 1; tna_a = 1; end
            if (!(cpu_read || cpu_write) || cdone) begin
                r = int'($urandom_range(0, 9));
                cpu_read  = (r < 3) || (r == 6);
                cpu_write = (r >= 3 && r <= 6);
                cpu_address    = 8'($urandom_range(0, 255));
                cpu_writedata  = $urandom();
                cpu_byteenable = 4'($urandom_range(0, 15));
            end
        end
        reset = 0; ta_a = 0; ta_b = 0; tna_a = 0; cpu_read = 0; cpu_write = 0;
        tick(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
